// File: rtl/wb_slave_pkg.sv
// Shared types and helpers for the WISHBONE register-file slave.
package wb_slave_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } wb_state_e;

    localparam int DEF_DEPTH = 16;
    localparam int IDX_W     = $clog2(DEF_DEPTH);
    localparam int CNT_W     = 4;

    // Byte-address bits that select a lane inside one data word.
    function automatic int lsb_of(input int dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/wb_regfile_mem.sv
// DEPTH x DW register array with byte-lane writes, async clear and a register-0 tap.
module wb_regfile_mem
    import wb_slave_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = DEF_DEPTH,
    parameter int IW    = IDX_W
) (
    input  logic            clk_i,
    input  logic            arst_i,
    input  logic            we_i,
    input  logic [DW/8-1:0] sel_i,
    input  logic [IW-1:0]   idx_i,
    input  logic [DW-1:0]   wdat_i,
    output logic [DW-1:0]   rdat_o,
    output logic [DW-1:0]   reg0_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            for (int b = 0; b < DW / 8; b++) begin
                if (sel_i[b]) begin
                    mem_q[idx_i][b*8 +: 8] <= wdat_i[b*8 +: 8];
                end
            end
        end
    end

    assign rdat_o = mem_q[idx_i];
    assign reg0_o = mem_q[0];

endmodule

// File: rtl/wb_slave_regfile.sv
// WISHBONE classic-cycle slave in front of a byte-writable register file.
// state  | meaning
// S_IDLE | waiting for cyc & stb; latches the request when seen
// S_WAIT | counting wait states; dropping cyc/stb aborts silently
// S_RESP | one-cycle ack or err, then back to idle
module wb_slave_regfile
    import wb_slave_pkg::*;
#(
    parameter int dwidth      = 32,
    parameter int awidth      = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic                wb_clk_i,
    input  logic                arst_i,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    input  logic                wb_we_i,
    input  logic [dwidth/8-1:0] wb_sel_i,
    input  logic [awidth-1:0]   wb_adr_i,
    input  logic [dwidth-1:0]   wb_dat_i,
    output logic [dwidth-1:0]   wb_dat_o,
    output logic                wb_ack_o,
    output logic                wb_err_o,
    output logic                wb_rty_o,
    output logic [dwidth-1:0]   ctrl_o
);

    localparam int LSB = lsb_of(dwidth);
    localparam int IW  = $clog2(DEPTH);
    localparam int SW  = dwidth / 8;

    wb_state_e          state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               we_q;
    logic [SW-1:0]      sel_q;
    logic [IW-1:0]      idx_q;
    logic [dwidth-1:0]  wdat_q;
    logic               oor_q;
    logic               ack_q;
    logic               err_q;
    logic [dwidth-1:0]  dat_q;

    logic               req;
    logic               in_oor;
    logic [IW-1:0]      in_idx;
    logic               cur_we;
    logic [SW-1:0]      cur_sel;
    logic [IW-1:0]      cur_idx;
    logic [dwidth-1:0]  cur_wdat;
    logic               cur_oor;
    logic               to_resp;
    logic               mem_we;
    logic [dwidth-1:0]  mem_rdat;

    assign req    = wb_cyc_i & wb_stb_i;
    assign in_oor = |(wb_adr_i >> (LSB + IW));
    assign in_idx = wb_adr_i[LSB +: IW];

    // With zero wait states the response is committed on the sampling edge,
    // so the live bus fields are used instead of the latched copies.
    always_comb begin
        cur_we   = we_q;
        cur_sel  = sel_q;
        cur_idx  = idx_q;
        cur_wdat = wdat_q;
        cur_oor  = oor_q;
        if (state_q == S_IDLE) begin
            cur_we   = wb_we_i;
            cur_sel  = wb_sel_i;
            cur_idx  = in_idx;
            cur_wdat = wb_dat_i;
            cur_oor  = in_oor;
        end
        to_resp = ((state_q == S_IDLE) && req && (WAIT_STATES == 0))
               || ((state_q == S_WAIT) && req && (cnt_q == '0));
        mem_we  = to_resp & cur_we & ~cur_oor;
    end

    wb_regfile_mem #(
        .DW    (dwidth),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_mem (
        .clk_i  (wb_clk_i),
        .arst_i (arst_i),
        .we_i   (mem_we),
        .sel_i  (cur_sel),
        .idx_i  (cur_idx),
        .wdat_i (cur_wdat),
        .rdat_o (mem_rdat),
        .reg0_o (ctrl_o)
    );

    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            idx_q   <= '0;
            wdat_q  <= '0;
            oor_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= '0;
            if (to_resp) begin
                ack_q <= ~cur_oor;
                err_q <= cur_oor;
                if (!cur_we && !cur_oor) begin
                    dat_q <= mem_rdat;
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        we_q    <= wb_we_i;
                        sel_q   <= wb_sel_i;
                        idx_q   <= in_idx;
                        wdat_q  <= wb_dat_i;
                        oor_q   <= in_oor;
                        cnt_q   <= CNT_W'(WAIT_STATES - 1);
                        state_q <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!req) begin
                        state_q <= S_IDLE;
                    end else if (cnt_q == '0) begin
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign wb_dat_o = dat_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_rty_o = 1'b0;

endmodule

// File: tb/tb_wb_slave_regfile.sv
// Bench for wb_slave_regfile: five instances with different wait states, one reference model each.
module tb_wb_slave_regfile;

    localparam int NDUT = 5;
    localparam int WS_TAB [NDUT] = '{0, 1, 3, 4, 15};

    int total = 0;
    int bad   = 0;

    logic              clk = 1'b0;
    logic              arst_n;
    logic [NDUT-1:0]   cyc_v;
    logic              stb;
    logic              we_b;
    logic [3:0]        sel_b;
    logic [31:0]       adr_b;
    logic [31:0]       wdat_b;
    logic [31:0]       dat_o_a [NDUT];
    logic [31:0]       ctrl_a  [NDUT];
    logic [NDUT-1:0]   ack_v;
    logic [NDUT-1:0]   err_v;
    logic [NDUT-1:0]   rty_v;

    logic [31:0]       model [NDUT][16];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        wb_slave_regfile #(
            .dwidth      (32),
            .awidth      (32),
            .DEPTH       (16),
            .WAIT_STATES (WS_TAB[g])
        ) u_dut (
            .wb_clk_i (clk),
            .arst_i   (arst_n),
            .wb_cyc_i (cyc_v[g]),
            .wb_stb_i (stb),
            .wb_we_i  (we_b),
            .wb_sel_i (sel_b),
            .wb_adr_i (adr_b),
            .wb_dat_i (wdat_b),
            .wb_dat_o (dat_o_a[g]),
            .wb_ack_o (ack_v[g]),
            .wb_err_o (err_v[g]),
            .wb_rty_o (rty_v[g]),
            .ctrl_o   (ctrl_a[g])
        );
    end

    task automatic clear_model();
        for (int d = 0; d < NDUT; d++)
            for (int i = 0; i < 16; i++)
                model[d][i] = 32'h0;
    endtask

    // Classic single cycle: request presented just after an edge, held until ack/err, dropped one edge later.
    task automatic xfer(input int d, input logic we, input logic [31:0] adr,
                        input logic [3:0] sel, input logic [31:0] wd,
                        output logic [31:0] rd, output logic ack, output logic err,
                        output int lat, output logic [31:0] ctrl_at,
                        output logic resp_after, output logic [31:0] dat_after);
        @(posedge clk); #1;
        cyc_v  = NDUT'(1 << d);
        stb    = 1'b1;
        we_b   = we;
        adr_b  = adr;
        sel_b  = sel;
        wdat_b = wd;
        lat = -1; ack = 1'b0; err = 1'b0; rd = 32'h0; ctrl_at = 32'h0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (ack_v[d] || err_v[d]) begin
                ack = ack_v[d]; err = err_v[d]; rd = dat_o_a[d]; ctrl_at = ctrl_a[d];
                lat = n;
                break;
            end
        end
        @(posedge clk); #1;
        resp_after = ack_v[d] | err_v[d];
        dat_after  = dat_o_a[d];
        cyc_v = '0; stb = 1'b0; we_b = 1'b0;
    endtask

    task automatic do_op(input int d, input logic we, input logic [31:0] adr,
                         input logic [3:0] sel, input logic [31:0] wd,
                         output logic [31:0] rd);
        logic        oor, ack, err, resp_after;
        logic [31:0] exp_rd, ctrl_at, dat_after;
        int          idx, lat;
        oor = (adr >> 6) != 32'h0;
        idx = int'(adr[5:2]);
        if (we && !oor)
            for (int b = 0; b < 4; b++)
                if (sel[b]) model[d][idx][b*8 +: 8] = wd[b*8 +: 8];
        exp_rd = (!we && !oor) ? model[d][idx] : 32'h0;
        xfer(d, we, adr, sel, wd, rd, ack, err, lat, ctrl_at, resp_after, dat_after);
        total++;
        if (ack !== !oor) begin
            bad++;
            $display("FAIL ack observed=%0h expected=%0h", ack, !oor);
        end
        total++;
        if (err !== oor) begin
            bad++;
            $display("FAIL err observed=%0h expected=%0h", err, oor);
        end
        total++;
        if (rd !== exp_rd) begin
            bad++;
            $display("FAIL rdat observed=%0h expected=%0h", rd, exp_rd);
        end
        total++;
        if (lat !== WS_TAB[d] + 1) begin
            bad++;
            $display("FAIL latency observed=%0d expected=%0d", lat, WS_TAB[d] + 1);
        end
        total++;
        if (resp_after !== 1'b0) begin
            bad++;
            $display("FAIL pulse_width observed=%0h expected=0", resp_after);
        end
        total++;
        if (dat_after !== 32'h0) begin
            bad++;
            $display("FAIL dat_after_resp observed=%0h expected=0", dat_after);
        end
        total++;
        if (ctrl_at !== model[d][0]) begin
            bad++;
            $display("FAIL ctrl_at_resp observed=%0h expected=%0h", ctrl_at, model[d][0]);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, adr;
        logic        seen;
        logic [3:0]  sel;
        logic        we;

        arst_n = 1'b0; cyc_v = '0; stb = 1'b0; we_b = 1'b0;
        sel_b = '0; adr_b = '0; wdat_b = '0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            total++;
            if (ack_v[d] !== 1'b0) begin
                bad++;
                $display("FAIL reset_ack observed=%0h expected=0", ack_v[d]);
            end
            total++;
            if (ctrl_a[d] !== 32'h0) begin
                bad++;
                $display("FAIL reset_ctrl observed=%0h expected=0", ctrl_a[d]);
            end
        end
        total++;
        if (rty_v !== 5'b0) begin
            bad++;
            $display("FAIL rty_tied observed=%0h expected=0", rty_v);
        end
        arst_n = 1'b1;

        // Write/read across all wait-state settings.
        for (int d = 0; d < NDUT; d++) begin
            do_op(d, 1'b1, 32'h8, 4'hF, 32'hDEADBEEF, rd);
            do_op(d, 1'b0, 32'h8, 4'hF, 32'h0, rd);
            total++;
            if (rd !== 32'hDEADBEEF) begin
                bad++;
                $display("FAIL wr_rd_deadbeef observed=%0h expected=deadbeef", rd);
            end
        end

        // Byte lanes.
        do_op(1, 1'b1, 32'h4, 4'hF, 32'hFFFFFFFF, rd);
        do_op(1, 1'b1, 32'h4, 4'b0101, 32'h00000000, rd);
        do_op(1, 1'b0, 32'h4, 4'hF, 32'h0, rd);
        total++;
        if (rd !== 32'hFF00FF00) begin
            bad++;
            $display("FAIL byte_lanes observed=%0h expected=ff00ff00", rd);
        end

        // Out of range.
        do_op(0, 1'b1, 32'h40, 4'hF, 32'h12345678, rd);
        do_op(0, 1'b0, 32'h40, 4'hF, 32'h0, rd);
        total++;
        if (ctrl_a[0] !== 32'h0) begin
            bad++;
            $display("FAIL oor_reg0_untouched observed=%0h expected=0", ctrl_a[0]);
        end

        // Control tap.
        do_op(4, 1'b1, 32'h0, 4'hF, 32'hA5A50001, rd);
        total++;
        if (ctrl_a[4] !== 32'hA5A50001) begin
            bad++;
            $display("FAIL ctrl_tap observed=%0h expected=a5a50001", ctrl_a[4]);
        end

        // Abort during wait states.
        do_op(3, 1'b1, 32'hC, 4'hF, 32'h11112222, rd);
        @(posedge clk); #1;
        cyc_v = NDUT'(1 << 3); stb = 1'b1; we_b = 1'b1;
        adr_b = 32'hC; sel_b = 4'hF; wdat_b = 32'h33334444;
        repeat (2) @(posedge clk);
        #1;
        cyc_v = '0; stb = 1'b0; we_b = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (ack_v[3] || err_v[3]) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL abort_no_resp observed=%0h expected=0", seen);
        end
        do_op(3, 1'b0, 32'hC, 4'hF, 32'h0, rd);
        total++;
        if (rd !== 32'h11112222) begin
            bad++;
            $display("FAIL abort_no_write observed=%0h expected=11112222", rd);
        end

        // Randomized traffic.
        for (int d = 0; d < NDUT; d++) begin
            for (int k = 0; k < 25; k++) begin
                adr = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) adr = adr | (32'h1 << $urandom_range(6, 31));
                sel = 4'($urandom);
                we  = 1'($urandom_range(0, 1));
                do_op(d, we, adr, sel, $urandom, rd);
            end
        end

        // Reset in the middle of a write with three wait states.
        do_op(2, 1'b1, 32'h0, 4'hF, 32'hCAFE0001, rd);
        @(posedge clk); #1;
        cyc_v = NDUT'(1 << 2); stb = 1'b1; we_b = 1'b1;
        adr_b = 32'h8; sel_b = 4'hF; wdat_b = 32'h5555AAAA;
        repeat (2) @(posedge clk);
        #3;
        arst_n = 1'b0;
        #1;
        total++;
        if (ack_v[2] !== 1'b0) begin
            bad++;
            $display("FAIL midreset_ack observed=%0h expected=0", ack_v[2]);
        end
        total++;
        if (err_v[2] !== 1'b0) begin
            bad++;
            $display("FAIL midreset_err observed=%0h expected=0", err_v[2]);
        end
        total++;
        if (dat_o_a[2] !== 32'h0) begin
            bad++;
            $display("FAIL midreset_dat observed=%0h expected=0", dat_o_a[2]);
        end
        total++;
        if (ctrl_a[2] !== 32'h0) begin
            bad++;
            $display("FAIL midreset_ctrl observed=%0h expected=0", ctrl_a[2]);
        end
        cyc_v = '0; stb = 1'b0; we_b = 1'b0;
        clear_model();
        @(posedge clk); #2;
        arst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (ack_v[2] || err_v[2]) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL midreset_no_ack observed=%0h expected=0", seen);
        end
        do_op(2, 1'b0, 32'h8, 4'hF, 32'h0, rd);
        total++;
        if (rd !== 32'h0) begin
            bad++;
            $display("FAIL midreset_readback observed=%0h expected=0", rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
